fma_issue_arbiter: RTL and testbench

- Shares one fully pipelined FP FMA datapath (fixed latency, no stall input, no valid of its own) between NREQ requesters, e.g. the scalar FP issue port and vector lanes.
- Round-robin grants one request per cycle and drives the FMA operand/rounding/op buses.
- Tracks in-flight ops in a LAT-deep tag pipeline, then buffers results in a response FIFO with ready/valid backpressure.
- Credit counting guarantees that every issued op has a FIFO slot when its result emerges.

---
 rtl/fma_issue_arbiter_pkg.sv | 12 +
 rtl/fma_issue_arbiter_rr_arbiter.sv | 42 ++++
 rtl/fma_issue_arbiter.sv | 165 ++++++++++++++++
 tb/tb_fma_issue_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fma_issue_arbiter_pkg.sv
// Shared field widths and micro-op encodings for the FMA issue arbiter.
package fma_issue_arbiter_pkg;
  localparam int RM_W = 3;
  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    FMA_OP_FMADD  = 4'd0,
    FMA_OP_FMSUB  = 4'd1,
    FMA_OP_FNMADD = 4'd2,
    FMA_OP_FNMSUB = 4'd3
  } fma_op_e;
endpackage

// File: rtl/fma_issue_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans from the last winner + 1, owns the priority pointer.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_i,
  input  logic                    en_i,
  input  logic                    upd_i,
  output logic [NREQ-1:0]         gnt_o,
  output logic [$clog2(NREQ)-1:0] idx_o
);
  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int            c;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    c     = 0;
    if (en_i) begin
      for (int k = 1; k <= NREQ; k++) begin
        c = (int'(ptr_q) + k) % NREQ;
        if (!found && req_i[c]) begin
          found    = 1'b1;
          gnt_o[c] = 1'b1;
          idx_o    = IW'(c);
        end
      end
    end
    ptr_d = upd_i ? idx_o : ptr_q;
  end

  // Reset to the last index so requester 0 wins the first scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= IW'(NREQ - 1);
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/fma_issue_arbiter.sv
// Shares one fixed-latency FMA among NREQ requesters with credit-protected response FIFO.
// Optional synchronous flush port enabled by FMA_ARB_FLUSH_EN.
module fma_issue_arbiter
  import fma_issue_arbiter_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int LAT      = 3,
  parameter int RQ_DEPTH = 4,
  parameter int DW       = 32,
  parameter int TAGW     = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef FMA_ARB_FLUSH_EN
  input  logic                    flush,
`endif
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*RM_W-1:0]    req_rm,
  input  logic [NREQ*OP_W-1:0]    req_op,
  input  logic [NREQ*DW-1:0]      req_a,
  input  logic [NREQ*DW-1:0]      req_b,
  input  logic [NREQ*DW-1:0]      req_c,
  input  logic [NREQ*TAGW-1:0]    req_tag,
  output logic                    fma_valid,
  output logic [RM_W-1:0]         fma_rm,
  output logic [OP_W-1:0]         fma_op,
  output logic [DW-1:0]           fma_a,
  output logic [DW-1:0]           fma_b,
  output logic [DW-1:0]           fma_c,
  input  logic [DW-1:0]           fma_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [TAGW-1:0]         rsp_tag,
  output logic [DW-1:0]           rsp_data
);
  localparam int IW = $clog2(NREQ);
  localparam int AW = $clog2(RQ_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [RM_W-1:0] rm;
    logic [OP_W-1:0] op;
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [DW-1:0]   c;
    logic [TAGW-1:0] tag;
  } fma_req_t;

  typedef struct packed {
    logic [IW-1:0]   id;
    logic [TAGW-1:0] tag;
    logic [DW-1:0]   data;
  } fma_rsp_t;

  logic flush_w;
`ifdef FMA_ARB_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  fma_req_t [NREQ-1:0] req;
  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign req[i] = '{rm:  req_rm[i*RM_W +: RM_W], op: req_op[i*OP_W +: OP_W],
                      a:   req_a[i*DW +: DW],      b:  req_b[i*DW +: DW],
                      c:   req_c[i*DW +: DW],      tag: req_tag[i*TAGW +: TAGW]};
  end

  logic [CW-1:0]   credits_q, credits_d;
  logic            arb_en, issue, push, pop, full;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  fma_req_t        sel;

  // Reset gates the grant too, so req_ready reads 0 the moment rst_n drops.
  assign arb_en = rst_n & ~flush_w & (credits_q != '0);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_valid),
    .en_i  (arb_en),
    .upd_i (issue),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign req_ready = gnt;
  assign issue     = |(req_valid & gnt);
  assign sel       = req[gnt_idx];
  assign fma_valid = issue;
  assign fma_rm    = sel.rm;
  assign fma_op    = sel.op;
  assign fma_a     = sel.a;
  assign fma_b     = sel.b;
  assign fma_c     = sel.c;

  logic [LAT-1:0]           vld_pipe_q;
  logic [LAT-1:0][IW-1:0]   id_pipe_q;
  logic [LAT-1:0][TAGW-1:0] tag_pipe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
      tag_pipe_q <= '0;
    end else begin
      for (int s = LAT - 1; s > 0; s--) begin
        vld_pipe_q[s] <= vld_pipe_q[s-1];
        id_pipe_q[s]  <= id_pipe_q[s-1];
        tag_pipe_q[s] <= tag_pipe_q[s-1];
      end
      vld_pipe_q[0] <= issue;
      id_pipe_q[0]  <= gnt_idx;
      tag_pipe_q[0] <= sel.tag;
      if (flush_w) vld_pipe_q <= '0;
    end
  end

  fma_rsp_t      mem_q [RQ_DEPTH];
  logic [CW-1:0] wr_q, rd_q;
  fma_rsp_t      head;

  assign push      = vld_pipe_q[LAT-1];
  assign rsp_valid = (wr_q != rd_q);
  assign pop       = rsp_valid & rsp_ready;
  assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head      = mem_q[rd_q[AW-1:0]];
  assign rsp_id    = head.id;
  assign rsp_tag   = head.tag;
  assign rsp_data  = head.data;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= '{id: id_pipe_q[LAT-1], tag: tag_pipe_q[LAT-1], data: fma_result};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_w) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // A slot freed by a pop only becomes a credit on the following cycle.
  always_comb begin
    credits_d = credits_q - CW'(issue) + CW'(pop);
    if (flush_w) credits_d = CW'(RQ_DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) credits_q <= CW'(RQ_DEPTH);
    else        credits_q <= credits_d;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
  a_credit_max:  assert property (@(posedge clk) disable iff (!rst_n) credits_q <= CW'(RQ_DEPTH));
endmodule

// File: tb/tb_fma_issue_arbiter.sv
// Randomized bench: queue-based reference model plus hand-computed literal checks.
module tb_fma_issue_arbiter;
  localparam int NREQ = 2, LAT = 3, RQ_DEPTH = 4, DW = 32, TAGW = 10;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 fl = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*3-1:0]    req_rm = '0;
  logic [NREQ*4-1:0]    req_op = '0;
  logic [NREQ*DW-1:0]   req_a = '0, req_b = '0, req_c = '0;
  logic [NREQ*TAGW-1:0] req_tag = '0;
  logic                 fma_valid;
  logic [2:0]           fma_rm;
  logic [3:0]           fma_op;
  logic [DW-1:0]        fma_a, fma_b, fma_c, fma_result;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b0;
  logic [0:0]           rsp_id;
  logic [TAGW-1:0]      rsp_tag;
  logic [DW-1:0]        rsp_data;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  fma_issue_arbiter #(.NREQ(NREQ), .LAT(LAT), .RQ_DEPTH(RQ_DEPTH), .DW(DW), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef FMA_ARB_FLUSH_EN
    .flush(fl),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_rm(req_rm), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_tag(req_tag),
    .fma_valid(fma_valid), .fma_rm(fma_rm), .fma_op(fma_op),
    .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_result(fma_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_tag(rsp_tag), .rsp_data(rsp_data)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // fp32 <-> real for exactly representable small values
  function automatic logic [31:0] to32(input real r);
    logic [63:0] d;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction

  function automatic real from32(input logic [31:0] f);
    if (f[30:23] == 8'd0) return 0.0;
    return $bitstoreal({f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0});
  endfunction

  // Stand-in FMA: a*b+c, with op/rm folded into the top bits so those buses are observable
  function automatic logic [31:0] fval(input logic [31:0] a, b, c, input logic [3:0] op, input logic [2:0] rm);
    return to32(from32(a) * from32(b) + from32(c)) ^ {op, rm, 25'd0};
  endfunction

  logic [DW-1:0] sh [LAT];
  always @(posedge clk) begin
    for (int s = LAT - 1; s > 0; s--) sh[s] <= sh[s-1];
    sh[0] <= fval(fma_a, fma_b, fma_c, fma_op, fma_rm);
  end
  assign fma_result = sh[LAT-1];

  typedef struct {
    int              vis;
    int              id;
    logic [TAGW-1:0] tag;
    logic [DW-1:0]   data;
  } ent_t;

  ent_t inflight[$];
  ent_t fifo[$];
  int   m_ptr = NREQ - 1;
  int   cyc = 0;

  // Reference model: credits are whatever the in-flight and buffered queues leave free.
  always @(negedge clk) begin
    int g, c, s, avail;
    logic [NREQ-1:0] exp_rdy;
    if (!rst_n) begin
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_fma_valid", 64'(fma_valid), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      m_ptr = NREQ - 1;
      inflight.delete();
      fifo.delete();
    end else begin
      avail = RQ_DEPTH - inflight.size() - fifo.size();
      g = -1;
      if (avail > 0 && !fl)
        for (int k = 1; k <= NREQ; k++) begin
          c = (m_ptr + k) % NREQ;
          if (g < 0 && req_valid[c]) g = c;
        end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      s = (g < 0) ? 0 : g;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("fma_valid", 64'(fma_valid), 64'(g >= 0));
      chk("fma_a", 64'(fma_a), 64'(req_a[s*DW +: DW]));
      chk("fma_b", 64'(fma_b), 64'(req_b[s*DW +: DW]));
      chk("fma_c", 64'(fma_c), 64'(req_c[s*DW +: DW]));
      chk("fma_op", 64'(fma_op), 64'(req_op[s*4 +: 4]));
      chk("fma_rm", 64'(fma_rm), 64'(req_rm[s*3 +: 3]));
      chk("rsp_valid", 64'(rsp_valid), 64'(fifo.size() > 0));
      if (fifo.size() > 0) begin
        chk("rsp_id", 64'(rsp_id), 64'(fifo[0].id));
        chk("rsp_tag", 64'(rsp_tag), 64'(fifo[0].tag));
        chk("rsp_data", 64'(rsp_data), 64'(fifo[0].data));
        if (rsp_ready) void'(fifo.pop_front());
      end
      if (g >= 0) begin
        inflight.push_back('{vis: cyc + LAT + 1, id: g, tag: req_tag[g*TAGW +: TAGW],
                             data: fval(req_a[g*DW +: DW], req_b[g*DW +: DW], req_c[g*DW +: DW],
                                        req_op[g*4 +: 4], req_rm[g*3 +: 3])});
        m_ptr = g;
      end
      if (fl) begin
        inflight.delete();
        fifo.delete();
      end
      cyc++;
      while (inflight.size() > 0 && inflight[0].vis <= cyc) fifo.push_back(inflight.pop_front());
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    fl = 1'b0;
    next();
    next();
    rst_n = 1'b1;
  endtask

  task automatic rand_fields();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*DW +: DW] = to32(real'($urandom_range(0, 15)));
      req_b[i*DW +: DW] = to32(real'($urandom_range(0, 15)));
      req_c[i*DW +: DW] = to32(real'($urandom_range(0, 15)));
      req_op[i*4 +: 4]  = 4'($urandom_range(0, 3));
      req_rm[i*3 +: 3]  = 3'($urandom_range(0, 4));
      req_tag[i*TAGW +: TAGW] = TAGW'($urandom);
    end
  endtask

  initial begin
    int cnt;
    chk("model_7p0", 64'(to32(7.0)), 64'h40E00000);

    // Single op, 3*2+1 from requester 0
    req_valid = 2'b11;
    @(negedge clk);
    chk("in_reset_ready", 64'(req_ready), 64'd0);
    do_reset();
    req_valid = 2'b01;
    req_a[31:0] = 32'h40400000;
    req_b[31:0] = 32'h40000000;
    req_c[31:0] = 32'h3F800000;
    req_op[3:0] = 4'd0;
    req_rm[2:0] = 3'd0;
    req_tag[TAGW-1:0] = 10'h155;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("first_grant", 64'(req_ready), 64'd1);
    next();
    req_valid = '0;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (k <= LAT) chk("early_rsp", 64'(rsp_valid), 64'd0);
      else begin
        chk("lat_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("lat_rsp_id", 64'(rsp_id), 64'd0);
        chk("lat_rsp_data", 64'(rsp_data), 64'h40E00000);
        chk("lat_rsp_tag", 64'(rsp_tag), 64'h155);
      end
      next();
    end

    // Alternating grants from a fresh pointer
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      rand_fields();
      @(negedge clk);
      chk("alt_grant", 64'(req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
      next();
    end
    req_valid = '0;
    repeat (8) next();

    // Credit exhaustion, then a single-cycle pop frees exactly one issue next cycle
    do_reset();
    req_valid = 2'b01;
    cnt = 0;
    repeat (8) begin
      rand_fields();
      @(negedge clk);
      cnt += int'(req_ready[0]);
      next();
    end
    chk("credit_issues", 64'(cnt), 64'd4);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("pop_same_cycle", 64'(req_ready), 64'd0);
    next();
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("pop_next_cycle", 64'(req_ready), 64'd1);
    next();
    @(negedge clk);
    chk("pop_one_only", 64'(req_ready), 64'd0);
    next();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (8) next();

    // Reset with two ops in flight
    do_reset();
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    rand_fields();
    next();
    rand_fields();
    next();
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 64'(req_ready), 64'd0);
    chk("midrst_rspv", 64'(rsp_valid), 64'd0);
    next();
    rst_n = 1'b1;
    req_valid = '0;
    repeat (LAT + 3) begin
      @(negedge clk);
      chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
      next();
    end

`ifdef FMA_ARB_FLUSH_EN
    // 1 buffered + 3 in flight, then flush
    do_reset();
    req_valid = 2'b01;
    repeat (4) begin
      rand_fields();
      next();
    end
    req_valid = '0;
    fl = 1'b1;
    @(negedge clk);
    chk("preflush_buffered", 64'(rsp_valid), 64'd1);
    next();
    fl = 1'b0;
    rsp_ready = 1'b1;
    repeat (LAT + 2) begin
      @(negedge clk);
      chk("flush_no_rsp", 64'(rsp_valid), 64'd0);
      next();
    end
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    cnt = 0;
    repeat (6) begin
      rand_fields();
      @(negedge clk);
      cnt += int'(req_ready[0]);
      next();
    end
    chk("flush_credits", 64'(cnt), 64'd4);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (8) next();
`endif

    // Randomized traffic with varying backpressure
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rand_fields();
      req_valid = NREQ'($urandom);
      case ((i / 50) % 4)
        0: rsp_ready = 1'b1;
        1: rsp_ready = ($urandom_range(0, 3) == 0);
        2: rsp_ready = ($urandom_range(0, 1) == 0);
        default: rsp_ready = ($urandom_range(0, 7) != 0);
      endcase
      next();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (10) next();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
